// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path (shifter and sequence detector).
// State encoding for the shifter FSM and the common idle line level live here so
// both ends of the link agree on what an idle line looks like.
package serial_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SHIFT  = 2'b01;
    localparam logic [1:0] ST_PARITY = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_PARITY = ST_PARITY
    } ser_state_t;

    // Line level while no data or parity bit is on the wire; keeps the detector in its start state.
    localparam logic SER_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_shifter.sv
// Parallel-in / serial-out shifter: accepts WIDTH-bit words over valid/ready and
// drives them MSB-first onto dout, one bit per clock.
// Optional feature macro SER_PARITY_EN: appends one even-parity bit after bit 0
// (no gapless streaming in that build, since the parity cycle never accepts a word).
module serial_tx_shifter
    import serial_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef SER_PARITY_EN
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
`endif

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_dout;
    logic             r_valid;
    logic             r_done;

    ser_state_t       w_state;
    logic [WIDTH-1:0] w_shift;
    logic [CW-1:0]    w_cnt;
    logic             w_dout;
    logic             w_valid;
    logic             w_done;
    logic             w_ready;
    logic             w_xfer;

`ifdef SER_PARITY_EN
    logic             r_parity;
    logic             w_parity;
`endif

    // State, shift register, counter and registered line outputs; reset puts the line idle at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_dout   <= IDLE_LEVEL;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_cnt    <= w_cnt;
            r_dout   <= w_dout;
            r_valid  <= w_valid;
            r_done   <= w_done;
`ifdef SER_PARITY_EN
            r_parity <= w_parity;
`endif
        end
    end

    // Next-state and next-output logic: r_cnt is the index (0 = MSB) of the bit currently on dout.
    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        w_dout  = IDLE_LEVEL;
        w_valid = 1'b0;
        w_done  = 1'b0;
        w_ready = 1'b0;
`ifdef SER_PARITY_EN
        w_parity = r_parity;
`endif

        case (r_state)
            S_IDLE:  w_ready = 1'b1;
`ifndef SER_PARITY_EN
            S_SHIFT: w_ready = (r_cnt == LAST);
`endif
            default: w_ready = 1'b0;
        endcase
        w_xfer = load_valid && w_ready;

        case (r_state)
            S_SHIFT: begin
                if (r_cnt != LAST) begin
                    w_shift = r_shift << 1;
                    w_cnt   = r_cnt + 1'b1;
                    w_dout  = r_shift[WIDTH-2];
                    w_valid = 1'b1;
`ifndef SER_PARITY_EN
                    w_done  = (r_cnt == LAST_M1);
`endif
                end else begin
                    w_cnt = '0;
`ifdef SER_PARITY_EN
                    w_state = S_PARITY;
                    w_dout  = r_parity;
                    w_valid = 1'b1;
                    w_done  = 1'b1;
`else
                    w_state = S_IDLE;
`endif
                end
            end
            S_PARITY: w_state = S_IDLE;
            default:  w_state = S_IDLE;
        endcase

        if (w_xfer) begin
            w_state = S_SHIFT;
            w_shift = load_data;
            w_cnt   = '0;
            w_dout  = load_data[WIDTH-1];
            w_valid = 1'b1;
            w_done  = 1'b0;
`ifdef SER_PARITY_EN
            w_parity = ^load_data;
`endif
        end
    end

    assign load_ready = w_ready;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign word_done  = r_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Self-checking bench for serial_tx_shifter: a queue-based model of the line
// (one entry per driven bit) is compared against the DUT every cycle, plus
// directed literal checks for the key scenarios. Honours SER_PARITY_EN.
module tb_serial_tx_shifter;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lv = 1'b0;
    logic [7:0] ld = '0;
    logic       ready, dout, dvalid, busy, done;

    logic       lv4 = 1'b0;
    logic [3:0] ld4 = '0;
    logic       ready4, dout4, dvalid4, busy4, done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx_shifter #(.WIDTH(W)) u8 (
        .clk(clk), .reset_n(reset_n), .load_valid(lv), .load_ready(ready),
        .load_data(ld), .dout(dout), .dout_valid(dvalid), .busy(busy), .word_done(done)
    );

    serial_tx_shifter #(.WIDTH(4)) u4 (
        .clk(clk), .reset_n(reset_n), .load_valid(lv4), .load_ready(ready4),
        .load_data(ld4), .dout(dout4), .dout_valid(dvalid4), .busy(busy4), .word_done(done4)
    );

    // Compare one value and report a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of bits still to appear on the line; entry 0 is the bit on the line now.
    typedef struct packed { logic b; logic d; } item_t;
    item_t mq[$];
    logic  m_xfer;

    function automatic logic modelReady();
        if (PAR) return (mq.size() == 0);
        return (mq.size() <= 1);
    endfunction

    // Model advance: retire the current bit, append a whole word when a transfer happens.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
        end else begin
            m_xfer = lv && modelReady();
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_xfer) begin
                for (int i = W - 1; i >= 0; i--)
                    mq.push_back('{b: ld[i], d: (i == 0) && !PAR});
                if (PAR) mq.push_back('{b: ^ld, d: 1'b1});
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (mq.size() > 0) begin
            checkOutput("dout", dout, mq[0].b);
            checkOutput("dout_valid", dvalid, 1);
            checkOutput("word_done", done, mq[0].d);
            checkOutput("busy", busy, 1);
        end else begin
            checkOutput("dout_idle", dout, 1);
            checkOutput("dout_valid_idle", dvalid, 0);
            checkOutput("word_done_idle", done, 0);
            checkOutput("busy_idle", busy, 0);
        end
        checkOutput("load_ready", ready, modelReady());
    end

    // Capture of valid bits for literal sequence checks.
    logic capq[$];
    logic expq[$];
    always @(negedge clk) if (dvalid === 1'b1) capq.push_back(dout);

    task automatic pushExp(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) expq.push_back(w[i]);
        if (PAR) expq.push_back(^w);
    endtask

    task automatic compareCapture(input string name);
        checkOutput({name, "_len"}, capq.size(), expq.size());
        for (int i = 0; i < capq.size() && i < expq.size(); i++)
            checkOutput(name, capq[i], expq[i]);
        capq.delete();
        expq.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the shifter accepts it (bounded wait).
    task automatic applyStimulus(input logic [7:0] w);
        bit got;
        got = 1'b0;
        lv = 1'b1;
        ld = w;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (ready === 1'b1) got = 1'b1;
        end
        checkOutput("ready_timeout", got, 1);
        tick();
        lv = 1'b0;
    endtask

    initial begin
        logic [3:0] w4;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle line after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("t6_dout", dout, 1);
            checkOutput("t6_valid", dvalid, 0);
            checkOutput("t6_done", done, 0);
        end

        // WIDTH=4 word 0101.
        w4 = 4'b0101;
        tick();
        lv4 = 1'b1;
        ld4 = w4;
        tick();
        lv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t1_dout", dout4, w4[3 - i]);
            checkOutput("t1_valid", dvalid4, 1);
            checkOutput("t1_busy", busy4, 1);
            checkOutput("t1_done", done4, (i == 3) && !PAR);
            checkOutput("t1_ready", ready4, (i == 3) && !PAR);
        end
        if (PAR) begin
            @(negedge clk);
            checkOutput("t1_par", dout4, 0);
            checkOutput("t1_par_done", done4, 1);
        end
        @(negedge clk);
        checkOutput("t1_idle_dout", dout4, 1);
        checkOutput("t1_idle_valid", dvalid4, 0);
        checkOutput("t1_idle_done", done4, 0);
        capq.delete();

        // Back-to-back A5 then 3C.
        tick();
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        repeat (12) tick();
        pushExp(8'hA5);
        pushExp(8'h3C);
        compareCapture("t2_bits");

        // Load attempt while busy is ignored; held word follows.
        applyStimulus(8'hF0);
        lv = 1'b1;
        ld = 8'h0F;
        repeat (3) tick();
        applyStimulus(8'h55);
        repeat (12) tick();
        pushExp(8'hF0);
        pushExp(8'h55);
        compareCapture("t3_bits");

        // Reset mid-word.
        applyStimulus(8'hFF);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t4_dout", dout, 1);
        checkOutput("t4_valid", dvalid, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_done", done, 0);
        capq.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(8'hC3);
        repeat (12) tick();
        pushExp(8'hC3);
        compareCapture("t4_bits");

`ifdef SER_PARITY_EN
        // Parity word 07.
        lv = 1'b1;
        ld = 8'h07;
        tick();
        lv = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checkOutput("t5_dout", dout, (i < 8) ? ((8'h07 >> (7 - i)) & 1) : 1);
            checkOutput("t5_done", done, (i == 8));
            checkOutput("t5_ready", ready, 0);
        end
        repeat (3) tick();
        capq.delete();
`endif

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 500; i++) begin
            lv = ($urandom_range(0, 3) != 0);
            ld = 8'($urandom);
            if (i == 250) begin
                #2 reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
            end else begin
                tick();
            end
        end
        lv = 1'b0;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
